edge_update_queue: RTL and testbench

- Upstream feeder for the arbitrage container stage.
- Accepts edge-weight updates (src, dst, weight) from the host-side register interface at any rate and buffers them in a FIFO.
- Issues the updates one at a time: drives the container's u_src/u_dst/u_e, pulses its active-high synchronous reset, then waits for its done before issuing the next update.
- Reports occupancy, drop count and per-update latency for the host to read.

---
 rtl/edge_update_queue_if.sv | 33 +++
 rtl/edge_update_queue.sv | 171 +++++++++++++++++
 tb/tb_edge_update_queue.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/edge_update_queue_if.sv
// Signal bundle between the host/container side and edge_update_queue.
// The host side drives pushes and the container's done. The queue drives status
// and the update fields going to the container.
interface edge_update_queue_if #(
  parameter int PRED_W   = 8,
  parameter int WEIGHT_W = 32,
  parameter int CNT_W    = 5
);
  logic                wr_en;
  logic [PRED_W-1:0]   wr_src;
  logic [PRED_W-1:0]   wr_dst;
  logic [WEIGHT_W-1:0] wr_e;
  logic                full;
  logic [CNT_W-1:0]    count;
  logic [PRED_W-1:0]   u_src;
  logic [PRED_W-1:0]   u_dst;
  logic [WEIGHT_W-1:0] u_e;
  logic                cont_reset;
  logic                cont_done;
  logic                busy;
  logic [15:0]         drop_cnt;
  logic [15:0]         last_lat;

  modport master (
    output wr_en, wr_src, wr_dst, wr_e, cont_done,
    input  full, count, u_src, u_dst, u_e, cont_reset, busy, drop_cnt, last_lat
  );

  modport slave (
    input  wr_en, wr_src, wr_dst, wr_e, cont_done,
    output full, count, u_src, u_dst, u_e, cont_reset, busy, drop_cnt, last_lat
  );
endinterface

// File: rtl/edge_update_queue.sv
// Edge-update feeder for the arbitrage container stage.
// Buffers host edge-weight updates in a FIFO. Each update is issued to the
// container in turn: the fields are loaded, cont_reset is pulsed, and the queue
// waits for cont_done. The queue reports occupancy, rejected pushes, and the
// latency of the last completed update.
// Optional build macro EDGE_UPDATE_COALESCE_EN: a push whose (src,dst) matches
// a queued entry overwrites that entry's weight and does not add a new entry.
module edge_update_queue #(
  parameter int PRED_W   = 8,
  parameter int WEIGHT_W = 32,
  parameter int DEPTH    = 16,
  parameter int CNT_W    = 5
) (
  input logic               clk,
  input logic               reset,
  edge_update_queue_if.slave bus
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_nextState;

  logic [PRED_W-1:0]   r_memSrc [DEPTH];
  logic [PRED_W-1:0]   r_memDst [DEPTH];
  logic [WEIGHT_W-1:0] r_memE   [DEPTH];
  logic [PTR_W-1:0]    r_wrPtr;
  logic [PTR_W-1:0]    r_rdPtr;
  logic [CNT_W-1:0]    r_count;

  logic [PRED_W-1:0]   r_uSrc;
  logic [PRED_W-1:0]   r_uDst;
  logic [WEIGHT_W-1:0] r_uE;
  logic [15:0]         r_dropCnt;
  logic [15:0]         r_lat;
  logic [15:0]         r_lastLat;
  logic                r_holdoff;

  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_drop;
  logic                w_coalesce;

  assign w_full = (r_count == CNT_W'(DEPTH));
  // r_holdoff inserts one idle cycle after each completion before the next pop.
  assign w_pop  = (r_state == S_IDLE) && !r_holdoff && (r_count != '0);

`ifdef EDGE_UPDATE_COALESCE_EN
  logic [PTR_W-1:0] w_matchIdx;

  // Search the queued entries for the newest (src,dst) match. A head that is being popped does not count.
  always_comb begin
    logic [PTR_W-1:0] w_slot;
    w_coalesce = 1'b0;
    w_matchIdx = '0;
    w_slot     = '0;
    for (int i = 0; i < DEPTH; i++) begin
      w_slot = r_rdPtr + PTR_W'(i);
      if (bus.wr_en && (CNT_W'(i) < r_count) && !(w_pop && (i == 0)) &&
          (r_memSrc[w_slot] == bus.wr_src) && (r_memDst[w_slot] == bus.wr_dst)) begin
        w_coalesce = 1'b1;
        w_matchIdx = w_slot;
      end
    end
  end
`else
  assign w_coalesce = 1'b0;
`endif

  assign w_push = bus.wr_en && !w_coalesce && !w_full;
  assign w_drop = bus.wr_en && !w_coalesce && w_full;

  // Storage array: a new entry is written at the tail, or a matched weight is overwritten in place.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_memSrc[r_wrPtr] <= bus.wr_src;
      r_memDst[r_wrPtr] <= bus.wr_dst;
      r_memE[r_wrPtr]   <= bus.wr_e;
    end
`ifdef EDGE_UPDATE_COALESCE_EN
    if (w_coalesce) begin
      r_memE[w_matchIdx] <= bus.wr_e;
    end
`endif
  end

  // FIFO pointers and occupancy. A simultaneous push and pop leaves the count unchanged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + PTR_W'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_nextState;
  end

  // FSM next state. Any unused encoding falls back to IDLE.
  always_comb begin
    w_nextState = S_IDLE;
    case (r_state)
      S_IDLE:   w_nextState = w_pop ? S_LAUNCH : S_IDLE;
      S_LAUNCH: w_nextState = S_WAIT;
      S_WAIT:   w_nextState = bus.cont_done ? S_IDLE : S_WAIT;
      default:  w_nextState = S_IDLE;
    endcase
  end

  // FSM outputs: the container reset pulse and the in-flight flag.
  always_comb begin
    bus.cont_reset = (r_state == S_LAUNCH);
    bus.busy       = (r_state == S_LAUNCH) || (r_state == S_WAIT);
  end

  // Issued fields, latency measurement, completion holdoff and drop counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_uSrc    <= '0;
      r_uDst    <= '0;
      r_uE      <= '0;
      r_lat     <= '0;
      r_lastLat <= '0;
      r_holdoff <= 1'b0;
      r_dropCnt <= '0;
    end else begin
      if (w_pop) begin
        r_uSrc <= r_memSrc[r_rdPtr];
        r_uDst <= r_memDst[r_rdPtr];
        r_uE   <= r_memE[r_rdPtr];
      end
      if (r_state == S_LAUNCH) begin
        r_lat <= '0;
      end else if ((r_state == S_WAIT) && (r_lat != 16'hFFFF)) begin
        r_lat <= r_lat + 16'd1;
      end
      if ((r_state == S_WAIT) && bus.cont_done) begin
        r_lastLat <= (r_lat == 16'hFFFF) ? 16'hFFFF : r_lat + 16'd1;
      end
      r_holdoff <= (r_state == S_WAIT) && bus.cont_done;
      if (w_drop && (r_dropCnt != 16'hFFFF)) begin
        r_dropCnt <= r_dropCnt + 16'd1;
      end
    end
  end

  assign bus.full     = w_full;
  assign bus.count    = r_count;
  assign bus.u_src    = r_uSrc;
  assign bus.u_dst    = r_uDst;
  assign bus.u_e      = r_uE;
  assign bus.drop_cnt = r_dropCnt;
  assign bus.last_lat = r_lastLat;
endmodule

// File: tb/tb_edge_update_queue.sv
// Directed testbench for edge_update_queue with a small behavioural container model.
module tb_edge_update_queue;
  localparam int PRED_W   = 8;
  localparam int WEIGHT_W = 32;
  localparam int DEPTH    = 16;
  localparam int CNT_W    = 5;

  typedef struct {
    logic [7:0]  src;
    logic [7:0]  dst;
    logic [31:0] e;
    int          delay;
    logic [15:0] expLat;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;

  edge_update_queue_if #(.PRED_W(PRED_W), .WEIGHT_W(WEIGHT_W), .CNT_W(CNT_W)) bus ();

  edge_update_queue #(
    .PRED_W(PRED_W), .WEIGHT_W(WEIGHT_W), .DEPTH(DEPTH), .CNT_W(CNT_W)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int assertCount   = 0;
  int failCount     = 0;
  int cycleNo       = 0;
  int lastPushEdge  = 0;
  int contDelay     = 1;
  bit contStall     = 1'b0;
  bit contForceDone = 1'b0;
  logic modelDone   = 1'b0;
  int modelCnt      = 0;
  bit modelArmed    = 1'b0;

  logic [7:0]  issSrc[$];
  logic [7:0]  issDst[$];
  logic [31:0] issE[$];
  int          issCycle[$];
  logic [7:0]  capSrc = '0;
  logic [7:0]  capDst = '0;
  logic [31:0] capE   = '0;
  int unstableCount   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cycleNo <= cycleNo + 1;

  assign bus.cont_done = contForceDone | modelDone;

  // The container model clears done on the reset pulse. It raises done contDelay edges later unless stalled.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      modelDone  <= 1'b0;
      modelCnt   <= 0;
      modelArmed <= 1'b0;
    end else if (bus.cont_reset) begin
      modelDone  <= 1'b0;
      modelCnt   <= 0;
      modelArmed <= 1'b1;
    end else if (modelArmed && !contStall) begin
      modelCnt <= modelCnt + 1;
      if (modelCnt + 1 >= contDelay) begin
        modelDone  <= 1'b1;
        modelArmed <= 1'b0;
      end
    end
  end

  // Record every issued update. Also watch that u_* stay constant while it is in flight.
  always @(negedge clk) begin
    if (reset && bus.cont_reset) begin
      issSrc.push_back(bus.u_src);
      issDst.push_back(bus.u_dst);
      issE.push_back(bus.u_e);
      issCycle.push_back(cycleNo);
      capSrc = bus.u_src;
      capDst = bus.u_dst;
      capE   = bus.u_e;
    end else if (reset && bus.busy) begin
      if (bus.u_src != capSrc || bus.u_dst != capDst || bus.u_e != capE) unstableCount++;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [7:0] s, input logic [7:0] d, input logic [31:0] e);
    @(negedge clk);
    bus.wr_en    = 1'b1;
    bus.wr_src   = s;
    bus.wr_dst   = d;
    bus.wr_e     = e;
    lastPushEdge = cycleNo + 1;
    @(negedge clk);
    bus.wr_en = 1'b0;
  endtask

  task automatic waitIdle(input string name, input int maxCycles);
    int n = 0;
    @(negedge clk);
    while ((bus.busy || bus.count != '0) && n < maxCycles) begin
      @(negedge clk);
      n++;
    end
    checkOutput({"idle_", name}, 64'(n < maxCycles), 64'd1);
  endtask

  task automatic clearIssued();
    issSrc.delete();
    issDst.delete();
    issE.delete();
    issCycle.delete();
  endtask

  vec_t vecs[4];

  initial begin
    logic [31:0] expE[$];
    logic [7:0]  expS[$];
    int          firstEdge;
    int          n;

    vecs[0] = '{8'h01, 8'h02, 32'h0000_0010, 4,  16'd5};
    vecs[1] = '{8'hFF, 8'h00, 32'hFFFF_FFFF, 1,  16'd2};
    vecs[2] = '{8'h55, 8'hAA, 32'h8000_0000, 10, 16'd11};
    vecs[3] = '{8'h00, 8'h00, 32'h0000_0000, 2,  16'd3};

    bus.wr_en  = 1'b0;
    bus.wr_src = '0;
    bus.wr_dst = '0;
    bus.wr_e   = '0;

    // Check outputs while reset is held.
    repeat (3) @(negedge clk);
    checkOutput("rst_count", 64'(bus.count), 64'd0);
    checkOutput("rst_full", 64'(bus.full), 64'd0);
    checkOutput("rst_busy", 64'(bus.busy), 64'd0);
    checkOutput("rst_cont_reset", 64'(bus.cont_reset), 64'd0);
    checkOutput("rst_u_e", 64'(bus.u_e), 64'd0);
    checkOutput("rst_drop", 64'(bus.drop_cnt), 64'd0);
    checkOutput("rst_lat", 64'(bus.last_lat), 64'd0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Issue single updates from the vector table.
    for (int v = 0; v < 4; v++) begin
      clearIssued();
      contDelay = vecs[v].delay;
      applyStimulus(vecs[v].src, vecs[v].dst, vecs[v].e);
      waitIdle($sformatf("vec%0d", v), 40);
      checkOutput($sformatf("vec%0d_issues", v), 64'(issSrc.size()), 64'd1);
      if (issSrc.size() >= 1) begin
        checkOutput($sformatf("vec%0d_src", v), 64'(issSrc[0]), 64'(vecs[v].src));
        checkOutput($sformatf("vec%0d_dst", v), 64'(issDst[0]), 64'(vecs[v].dst));
        checkOutput($sformatf("vec%0d_e", v), 64'(issE[0]), 64'(vecs[v].e));
        checkOutput($sformatf("vec%0d_launch_cycle", v), 64'(issCycle[0]), 64'(lastPushEdge + 1));
      end
      checkOutput($sformatf("vec%0d_last_lat", v), 64'(bus.last_lat), 64'(vecs[v].expLat));
      checkOutput($sformatf("vec%0d_busy", v), 64'(bus.busy), 64'd0);
      checkOutput($sformatf("vec%0d_u_e_held", v), 64'(bus.u_e), 64'(vecs[v].e));
    end

    // Done held high: each update is issued once, four cycles apart.
    clearIssued();
    contForceDone = 1'b1;
    applyStimulus(8'h21, 8'h22, 32'hA1);
    firstEdge = lastPushEdge;
    applyStimulus(8'h23, 8'h24, 32'hA2);
    applyStimulus(8'h25, 8'h26, 32'hA3);
    waitIdle("held_done", 60);
    repeat (6) @(negedge clk);
    checkOutput("held_done_issues", 64'(issSrc.size()), 64'd3);
    if (issSrc.size() == 3) begin
      checkOutput("held_done_first", 64'(issCycle[0]), 64'(firstEdge + 1));
      checkOutput("held_done_gap1", 64'(issCycle[1] - issCycle[0]), 64'd4);
      checkOutput("held_done_gap2", 64'(issCycle[2] - issCycle[1]), 64'd4);
      checkOutput("held_done_order", 64'({issE[0][7:0], issE[1][7:0], issE[2][7:0]}), 64'hA1A2A3);
    end
    checkOutput("held_done_lat", 64'(bus.last_lat), 64'd1);
    contForceDone = 1'b0;
    repeat (2) @(negedge clk);

    // Fill the FIFO while one update is stalled in flight. Three pushes are dropped, then all drain in order.
    clearIssued();
    contDelay = 2;
    contStall = 1'b1;
    applyStimulus(8'hC0, 8'hC1, 32'h1234);
    repeat (3) @(negedge clk);
    for (int i = 0; i < DEPTH + 3; i++) begin
      @(negedge clk);
      bus.wr_en  = 1'b1;
      bus.wr_src = 8'(i);
      bus.wr_dst = 8'(i + 8'h40);
      bus.wr_e   = 32'h100 + 32'(i);
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    checkOutput("burst_count", 64'(bus.count), 64'(DEPTH));
    checkOutput("burst_full", 64'(bus.full), 64'd1);
    checkOutput("burst_drop", 64'(bus.drop_cnt), 64'd3);
    checkOutput("burst_busy", 64'(bus.busy), 64'd1);
    contStall = 1'b0;
    waitIdle("burst", 300);
    checkOutput("burst_issues", 64'(issSrc.size()), 64'(DEPTH + 1));
    if (issSrc.size() == DEPTH + 1) begin
      checkOutput("burst_first_src", 64'(issSrc[0]), 64'hC0);
      for (int i = 0; i < DEPTH; i++) begin
        checkOutput($sformatf("burst_order%0d", i),
                    64'({issSrc[i+1], issDst[i+1], issE[i+1]}),
                    64'({8'(i), 8'(i + 8'h40), 32'h100 + 32'(i)}));
      end
    end
    checkOutput("burst_full_after", 64'(bus.full), 64'd0);
    checkOutput("burst_drop_after", 64'(bus.drop_cnt), 64'd3);

    // The same key is pushed twice while busy. A push matching the in-flight key is queued as a new entry.
    clearIssued();
    contDelay = 2;
    contStall = 1'b1;
    applyStimulus(8'h10, 8'h20, 32'h5);
    repeat (3) @(negedge clk);
    applyStimulus(8'h03, 8'h04, 32'hA);
    applyStimulus(8'h03, 8'h04, 32'hB);
`ifdef EDGE_UPDATE_COALESCE_EN
    checkOutput("dup_count", 64'(bus.count), 64'd1);
`else
    checkOutput("dup_count", 64'(bus.count), 64'd2);
`endif
    applyStimulus(8'h10, 8'h20, 32'h77);
`ifdef EDGE_UPDATE_COALESCE_EN
    checkOutput("dup_inflight_count", 64'(bus.count), 64'd2);
    expE = '{32'h5, 32'hB, 32'h77};
    expS = '{8'h10, 8'h03, 8'h10};
`else
    checkOutput("dup_inflight_count", 64'(bus.count), 64'd3);
    expE = '{32'h5, 32'hA, 32'hB, 32'h77};
    expS = '{8'h10, 8'h03, 8'h03, 8'h10};
`endif
    contStall = 1'b0;
    waitIdle("dup", 100);
    checkOutput("dup_issues", 64'(issSrc.size()), 64'(expE.size()));
    if (issSrc.size() == expE.size()) begin
      for (int i = 0; i < expE.size(); i++) begin
        checkOutput($sformatf("dup_e%0d", i), 64'(issE[i]), 64'(expE[i]));
        checkOutput($sformatf("dup_src%0d", i), 64'(issSrc[i]), 64'(expS[i]));
      end
    end

    // Asynchronous reset during WAIT abandons everything.
    contDelay = 3;
    contStall = 1'b1;
    applyStimulus(8'h31, 8'h32, 32'hDEAD);
    applyStimulus(8'h33, 8'h34, 32'hBEEF);
    applyStimulus(8'h35, 8'h36, 32'hCAFE);
    checkOutput("prerst_count", 64'(bus.count), 64'd2);
    checkOutput("prerst_busy", 64'(bus.busy), 64'd1);
    @(negedge clk);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(bus.busy), 64'd0);
    checkOutput("midrst_count", 64'(bus.count), 64'd0);
    checkOutput("midrst_u", 64'({bus.u_src, bus.u_dst, bus.u_e}), 64'd0);
    checkOutput("midrst_cont_reset", 64'(bus.cont_reset), 64'd0);
    checkOutput("midrst_drop", 64'(bus.drop_cnt), 64'd0);
    checkOutput("midrst_lat", 64'(bus.last_lat), 64'd0);
    checkOutput("midrst_full", 64'(bus.full), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    contStall = 1'b0;
    n = issSrc.size();
    repeat (10) @(negedge clk);
    checkOutput("postrst_no_issue", 64'(issSrc.size()), 64'(n));
    applyStimulus(8'h41, 8'h42, 32'h99);
    waitIdle("postrst", 40);
    checkOutput("postrst_issue", 64'(issSrc.size()), 64'(n + 1));
    checkOutput("postrst_lat", 64'(bus.last_lat), 64'd4);

    // A very long stall saturates last_lat.
    contDelay = 1;
    contStall = 1'b1;
    applyStimulus(8'h51, 8'h52, 32'h1);
    repeat (70000) @(negedge clk);
    checkOutput("sat_busy", 64'(bus.busy), 64'd1);
    contStall = 1'b0;
    waitIdle("sat", 50);
    checkOutput("sat_last_lat", 64'(bus.last_lat), 64'hFFFF);

    checkOutput("u_stable", 64'(unstableCount), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end
endmodule
